// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register for the MIPS datapath.
// Two-entry skid buffer (Main = head, Skid = overflow) behind a valid/ready
// handshake, so InReady comes straight from the state register. Flush squashes
// the stage in one edge. A saturating counter records cycles in which the
// stage held a live entry that downstream refused.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH          = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
  parameter bit               CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned      CNT_W          = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] DataIn,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData,
  output logic [CNT_W-1:0] StallCount
);

  // EMPTY: no entry; BUSY: Main live; FULL: Main and Skid live.
  // 2'b11 is unreachable and is steered back to EMPTY.
  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    BUSY    = 2'b01,
    FULL    = 2'b10,
    ILLEGAL = 2'b11
  } stageState_t;

  stageState_t      state;
  stageState_t      stateNext;
  logic [WIDTH-1:0] mainReg;
  logic [WIDTH-1:0] skidReg;
  logic [WIDTH-1:0] mainNext;
  logic [WIDTH-1:0] skidNext;
  logic             inFire;
  logic             outFire;
  logic             stallEvent;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    if (&value) begin
      return value;
    end
    return value + CNT_W'(1);
  endfunction

  assign InReady    = (state != FULL);
  assign OutValid   = (state != EMPTY);
  assign OutData    = mainReg;
  assign inFire     = InValid & InReady;
  assign outFire    = OutValid & OutReady;
  assign stallEvent = OutValid & ~OutReady;

  // Next-state and data-load decisions; Flush overrides every handshake.
  always_comb begin
    stateNext = state;
    mainNext  = mainReg;
    skidNext  = skidReg;
    if (Flush) begin
      // Any transfer in this cycle is dropped; upstream still sees it consumed.
      stateNext = EMPTY;
      if (CLEAR_ON_FLUSH) begin
        mainNext = RESET_VALUE;
        skidNext = RESET_VALUE;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (inFire) begin
            mainNext  = DataIn;
            stateNext = BUSY;
          end
        end
        BUSY: begin
          if (inFire && outFire) begin
            mainNext = DataIn;
          end else if (inFire) begin
            // Downstream stalled: park the new word behind the head.
            skidNext  = DataIn;
            stateNext = FULL;
          end else if (outFire) begin
            stateNext = EMPTY;
          end
        end
        FULL: begin
          // InReady is low here, so only the drain side can move.
          if (outFire) begin
            mainNext  = skidReg;
            stateNext = BUSY;
          end
        end
        default: begin
          stateNext = EMPTY;
        end
      endcase
    end
  end

  // State register; reset drops every entry.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  // Payload registers: head and overflow slot.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mainReg <= RESET_VALUE;
      skidReg <= RESET_VALUE;
    end else begin
      mainReg <= mainNext;
      skidReg <= skidNext;
    end
  end

  // Stall monitor; counts through flush cycles and clears only on reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      StallCount <= '0;
    end else if (stallEvent) begin
      StallCount <= satInc(StallCount);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default-parameter instance and a narrow
// instance (3-bit counter, data held on flush, non-zero reset value).
module tb_pipe_stage_reg;

  logic        Clk;
  logic        Rst;

  logic        Flush;
  logic        InValid;
  logic        InReady;
  logic [31:0] DataIn;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutData;
  logic [15:0] StallCount;

  logic        sFlush;
  logic        sInValid;
  logic        sInReady;
  logic [7:0]  sDataIn;
  logic        sOutValid;
  logic        sOutReady;
  logic [7:0]  sOutData;
  logic [2:0]  sStallCount;

  int compared   = 0;
  int mismatched = 0;

  pipe_stage_reg #(
    .WIDTH(32), .RESET_VALUE(32'h0), .CLEAR_ON_FLUSH(1'b1), .CNT_W(16)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .DataIn(DataIn), .OutValid(OutValid), .OutReady(OutReady),
    .OutData(OutData), .StallCount(StallCount)
  );

  pipe_stage_reg #(
    .WIDTH(8), .RESET_VALUE(8'h5A), .CLEAR_ON_FLUSH(1'b0), .CNT_W(3)
  ) dutSat (
    .Clk(Clk), .Rst(Rst), .Flush(sFlush), .InValid(sInValid), .InReady(sInReady),
    .DataIn(sDataIn), .OutValid(sOutValid), .OutReady(sOutReady),
    .OutData(sOutData), .StallCount(sStallCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b0; Flush = 1'b0; InValid = 1'b1; DataIn = 32'hDEADBEEF; OutReady = 1'b0;
    sFlush = 1'b0; sInValid = 1'b0; sDataIn = 8'h00; sOutReady = 1'b0;

    // T1 reset held for three edges with a word offered
    tick(); tick(); tick();
    check("t1_outvalid", OutValid, 0);
    check("t1_inready", InReady, 1);
    check("t1_outdata", OutData, 0);
    check("t1_stall", StallCount, 0);
    check("t1_sat_outdata", sOutData, 8'h5A);
    check("t1_sat_outvalid", sOutValid, 0);
    Rst = 1'b1; InValid = 1'b0;
    tick();
    check("t1_after_release", OutValid, 0);

    // T2 streaming with OutReady high
    OutReady = 1'b1; InValid = 1'b1; DataIn = 32'h1;
    tick();
    check("t2_data1", OutData, 32'h1);
    check("t2_valid1", OutValid, 1);
    check("t2_ready1", InReady, 1);
    DataIn = 32'h2;
    tick();
    check("t2_data2", OutData, 32'h2);
    check("t2_ready2", InReady, 1);
    DataIn = 32'h3;
    tick();
    check("t2_data3", OutData, 32'h3);
    check("t2_ready3", InReady, 1);
    InValid = 1'b0;
    tick();
    check("t2_drained", OutValid, 0);
    check("t2_stall", StallCount, 0);

    // T3 backpressure into FULL, hold, then drain in order
    OutReady = 1'b0; InValid = 1'b1; DataIn = 32'hA;
    tick();
    check("t3_busy_data", OutData, 32'hA);
    DataIn = 32'hB;
    tick();
    check("t3_full_inready", InReady, 0);
    check("t3_full_data", OutData, 32'hA);
    check("t3_full_valid", OutValid, 1);
    check("t3_stall1", StallCount, 1);
    InValid = 1'b0;
    tick();
    check("t3_hold_inready", InReady, 0);
    check("t3_hold_data", OutData, 32'hA);
    OutReady = 1'b1;
    tick();
    check("t3_second_data", OutData, 32'hB);
    check("t3_second_inready", InReady, 1);
    check("t3_second_valid", OutValid, 1);
    tick();
    check("t3_empty", OutValid, 0);
    check("t3_stall2", StallCount, 2);

    // T4 flush from FULL while a new word is offered
    OutReady = 1'b0; InValid = 1'b1; DataIn = 32'hA;
    tick();
    DataIn = 32'hB;
    tick();
    check("t4_full_inready", InReady, 0);
    Flush = 1'b1; DataIn = 32'hC;
    tick();
    check("t4_flush_valid", OutValid, 0);
    check("t4_flush_inready", InReady, 1);
    check("t4_flush_data", OutData, 0);
    check("t4_flush_stall", StallCount, 4);
    Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    tick();
    check("t4_no_c_valid", OutValid, 0);
    check("t4_no_c_data", OutData, 0);
    // flush from BUSY discarding a simultaneous in_fire
    OutReady = 1'b0; InValid = 1'b1; DataIn = 32'hD;
    tick();
    check("t4_busy_data", OutData, 32'hD);
    Flush = 1'b1; DataIn = 32'hE;
    tick();
    Flush = 1'b0; InValid = 1'b0;
    check("t4b_valid", OutValid, 0);
    check("t4b_data", OutData, 0);
    check("t4b_stall", StallCount, 5);
    tick();
    check("t4b_still_empty", OutValid, 0);

    // T5 saturation on the 3-bit counter, then flush that keeps data
    sInValid = 1'b1; sDataIn = 8'h77; sOutReady = 1'b0;
    tick();
    sInValid = 1'b0;
    check("t5_sat_data", sOutData, 8'h77);
    check("t5_sat_zero", sStallCount, 0);
    for (int i = 0; i < 7; i++) tick();
    check("t5_sat_at7", sStallCount, 7);
    for (int i = 0; i < 3; i++) tick();
    check("t5_sat_hold", sStallCount, 7);
    sFlush = 1'b1;
    tick();
    sFlush = 1'b0;
    check("t5_hold_flush_valid", sOutValid, 0);
    check("t5_hold_flush_data", sOutData, 8'h77);
    check("t5_hold_flush_stall", sStallCount, 7);
    check("t5_main_untouched", StallCount, 5);

    // T6 asynchronous reset between edges while FULL
    OutReady = 1'b0; InValid = 1'b1; DataIn = 32'h11;
    tick();
    DataIn = 32'h22;
    tick();
    InValid = 1'b0;
    check("t6_full_inready", InReady, 0);
    check("t6_full_stall", StallCount, 6);
    #2;
    Rst = 1'b0;
    #1;
    check("t6_async_valid", OutValid, 0);
    check("t6_async_inready", InReady, 1);
    check("t6_async_data", OutData, 0);
    check("t6_async_stall", StallCount, 0);
    check("t6_async_sat_data", sOutData, 8'h5A);
    check("t6_async_sat_stall", sStallCount, 0);
    tick();
    Rst = 1'b1;
    tick();
    check("t6_post_empty", OutValid, 0);
    OutReady = 1'b1; InValid = 1'b1; DataIn = 32'h33;
    tick();
    InValid = 1'b0;
    check("t6_post_data", OutData, 32'h33);
    check("t6_post_valid", OutValid, 1);
    tick();
    check("t6_post_drain", OutValid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
